// File: rtl/ibex_icache_fetch_checker_pkg.sv
// ibex_icache_fetch_checker_pkg
// Shared types for the instruction-fetch protocol checker:
//   state_e      - checker FSM states
//   viol_e       - bit index of each sticky violation flag
//   NUM_VIOL     - number of violation flags
//   first_viol() - lowest set violation index (0 when none set)
package ibex_icache_fetch_checker_pkg;

    localparam int NUM_VIOL = 8;

    typedef enum logic [1:0] {
        NO_ADDR = 2'd0,
        ARMED   = 2'd1,
        HOLD    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        V_NO_READY_WITHOUT_REQ = 3'd0,
        V_BRANCH_MISALIGNED    = 3'd1,
        V_BRANCH_NO_SPEC       = 3'd2,
        V_FETCH_NO_ADDR        = 3'd3,
        V_VALID_DROPPED        = 3'd4,
        V_RESP_UNSTABLE        = 3'd5,
        V_ADDR_SEQ             = 3'd6,
        V_TIMEOUT              = 3'd7
    } viol_e;

    function automatic logic [2:0] first_viol(input logic [NUM_VIOL-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_VIOL - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ibex_icache_fetch_checker_if.sv
// ibex_icache_fetch_checker_if
// Core <-> instruction cache fetch handshake as seen by the checker.
//   master : the side driving the bus (core + cache, or a testbench)
//   slave  : the passive observer (the checker)
// Signals: req, branch, branch_spec, branch_addr, ready, valid, rdata,
//          addr, err, err_plus2.
interface ibex_icache_fetch_checker_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              branch;
    logic              branch_spec;
    logic [ADDR_W-1:0] branch_addr;
    logic              ready;
    logic              valid;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic              err_plus2;

    modport master (
        output req, branch, branch_spec, branch_addr, ready,
        output valid, rdata, addr, err, err_plus2
    );

    modport slave (
        input req, branch, branch_spec, branch_addr, ready,
        input valid, rdata, addr, err, err_plus2
    );
endinterface

// File: rtl/ibex_icache_fetch_checker_hold.sv
// ibex_icache_fetch_checker_hold
// Captures a response offered while the core stalls and flags any change
// to it while it is still being offered.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   capture      load the current response into the capture registers
//   addr, err, err_plus2, rdata   live response
//   unstable     live response differs from the captured one
module ibex_icache_fetch_checker_hold #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [ADDR_W-1:0] addr,
    input  logic              err,
    input  logic              err_plus2,
    input  logic [31:0]       rdata,
    output logic              unstable
);
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              err_plus2_q;
    logic [15:0]       lo_q;
    logic [15:0]       hi_q;
    logic              uncomp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            err_q       <= 1'b0;
            err_plus2_q <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else if (capture) begin
            addr_q      <= addr;
            err_q       <= err;
            err_plus2_q <= err_plus2;
            lo_q        <= rdata[15:0];
            // Upper halfword only belongs to the instruction if uncompressed.
            hi_q        <= (rdata[1:0] == 2'b11) ? rdata[31:16] : 16'h0000;
        end
    end

    assign uncomp_q = (lo_q[1:0] == 2'b11);

    // Data is meaningless on an error response, so only metadata is compared.
    assign unstable = (addr != addr_q) | (err != err_q) | (err_plus2 != err_plus2_q) |
                      (~err_q & (rdata[15:0] != lo_q)) |
                      (~err_q & uncomp_q & (rdata[31:16] != hi_q));
endmodule

// File: rtl/ibex_icache_fetch_checker.sv
// ibex_icache_fetch_checker
// Passive protocol checker for the Ibex instruction-fetch interface.
// Tracks the expected fetch address after each redirect, checks that
// stalled responses stay stable, and records sticky violation flags.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           fetch handshake (slave modport, observe only)
//   clr           clear sticky violations (a same-cycle violation survives)
//   viol_o        sticky violation vector (see viol_e)
//   viol_any_o    OR of viol_o
//   viol_first_o  index of first violation since reset or clr
//   fetch_cnt_o   accepted non-error fetches, saturating
// Build option: define IBEX_FETCH_CHECKER_ASSERT_EN to compile in
// concurrent assertions on every violation and on control-input X.
module ibex_icache_fetch_checker
    import ibex_icache_fetch_checker_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ibex_icache_fetch_checker_if.slave  bus,
    input  logic                        clr,
    output logic [NUM_VIOL-1:0]         viol_o,
    output logic                        viol_any_o,
    output logic [2:0]                  viol_first_o,
    output logic [CNT_W-1:0]            fetch_cnt_o
);
    state_e              state_q;
    logic [ADDR_W-1:0]   exp_addr_q;
    logic [NUM_VIOL-1:0] viol_new;
    logic                accept;
    logic                hold_capture;
    logic                hold_unstable;
    logic                live_flag;

    assign accept       = (state_q != NO_ADDR) & bus.valid & bus.ready & ~bus.branch;
    assign hold_capture = (state_q == ARMED) & bus.valid & ~bus.ready & ~bus.branch;

    ibex_icache_fetch_checker_hold #(
        .ADDR_W(ADDR_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (hold_capture),
        .addr      (bus.addr),
        .err       (bus.err),
        .err_plus2 (bus.err_plus2),
        .rdata     (bus.rdata),
        .unstable  (hold_unstable)
    );

    // Liveness: core waiting on an armed cache that never responds.
    generate
        if (TIMEOUT > 0) begin : g_live
            localparam int LW = $clog2(TIMEOUT + 1);
            logic [LW-1:0] live_cnt_q;
            logic          live_run;
            logic          live_clr;

            assign live_run  = (state_q == ARMED) & bus.req & bus.ready & ~bus.valid & ~bus.branch;
            assign live_clr  = (state_q != ARMED) | bus.valid | bus.branch;
            // Flag on the transition into saturation, so only once per wait.
            assign live_flag = live_run & (live_cnt_q == LW'(TIMEOUT - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_cnt_q <= '0;
                end else if (live_clr) begin
                    live_cnt_q <= '0;
                end else if (live_run && (live_cnt_q != LW'(TIMEOUT))) begin
                    live_cnt_q <= live_cnt_q + 1'b1;
                end
            end
        end else begin : g_no_live
            assign live_flag = 1'b0;
        end
    endgenerate

    always_comb begin
        viol_new                         = '0;
        viol_new[V_NO_READY_WITHOUT_REQ] = bus.ready & ~bus.req;
        viol_new[V_BRANCH_MISALIGNED]    = bus.branch & bus.branch_addr[0];
        viol_new[V_BRANCH_NO_SPEC]       = bus.branch & ~bus.branch_spec;
        viol_new[V_FETCH_NO_ADDR]        = (state_q == NO_ADDR) & bus.ready & ~bus.branch;
        viol_new[V_VALID_DROPPED]        = (state_q == HOLD) & ~bus.branch & ~bus.valid;
        viol_new[V_RESP_UNSTABLE]        = (state_q == HOLD) & ~bus.branch & bus.valid & hold_unstable;
        viol_new[V_ADDR_SEQ]             = accept & (bus.addr != exp_addr_q);
        viol_new[V_TIMEOUT]              = live_flag;
    end

    // Address tracking FSM; a redirect overrides every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NO_ADDR;
            exp_addr_q  <= '0;
            fetch_cnt_o <= '0;
        end else if (bus.branch) begin
            state_q    <= ARMED;
            exp_addr_q <= bus.branch_addr;
        end else begin
            case (state_q)
                ARMED, HOLD: begin
                    if (accept) begin
                        if (bus.err) begin
                            state_q <= NO_ADDR;
                        end else begin
                            state_q    <= ARMED;
                            exp_addr_q <= exp_addr_q +
                                          ((bus.rdata[1:0] == 2'b11) ? ADDR_W'(4) : ADDR_W'(2));
                            if (fetch_cnt_o != '1) fetch_cnt_o <= fetch_cnt_o + 1'b1;
                        end
                    end else if (bus.valid) begin
                        state_q <= HOLD;
                    end else begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= NO_ADDR;
            endcase
        end
    end

    // Sticky flags; on clr the current cycle's violations seed the new set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_o       <= '0;
            viol_any_o   <= 1'b0;
            viol_first_o <= 3'd0;
        end else if (clr) begin
            viol_o       <= viol_new;
            viol_any_o   <= |viol_new;
            viol_first_o <= first_viol(viol_new);
        end else begin
            viol_o     <= viol_o | viol_new;
            viol_any_o <= |(viol_o | viol_new);
            if ((viol_o == '0) && (viol_new != '0)) viol_first_o <= first_viol(viol_new);
        end
    end

`ifdef IBEX_FETCH_CHECKER_ASSERT_EN
    for (genvar gi = 0; gi < NUM_VIOL; gi++) begin : g_viol_assert
        a_no_viol: assert property (@(posedge clk) disable iff (!rst_n) !viol_new[gi]);
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({bus.req, bus.branch, bus.branch_spec, bus.ready, bus.valid, clr}));
`else
    // Flag outputs only.
`endif

endmodule

// File: tb/tb_ibex_icache_fetch_checker.sv
module tb_ibex_icache_fetch_checker;
    localparam int TO      = 4;
    localparam int CNT_MAX = 15;
    localparam int M_NONE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_HOLD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic [7:0]  v0, v1;
    logic        a0, a1;
    logic [2:0]  f0, f1;
    logic [3:0]  c0;
    logic [15:0] c1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_exp;
    int          m_live;
    int          m_cnt;
    logic [7:0]  m_viol;
    int          m_first;
    logic [31:0] s_addr, s_rd;
    logic        s_err, s_ep2;

    always #5 clk = ~clk;

    ibex_icache_fetch_checker_if #(.ADDR_W(32)) bus ();

    ibex_icache_fetch_checker #(.ADDR_W(32), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
        .viol_o(v0), .viol_any_o(a0), .viol_first_o(f0), .fetch_cnt_o(c0)
    );

    ibex_icache_fetch_checker #(.ADDR_W(32), .TIMEOUT(0), .CNT_W(16)) dut_nt (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
        .viol_o(v1), .viol_any_o(a1), .viol_first_o(f1), .fetch_cnt_o(c1)
    );

    task automatic idle();
        bus.req = 1'b0; bus.branch = 1'b0; bus.branch_spec = 1'b1; bus.branch_addr = '0;
        bus.ready = 1'b0; bus.valid = 1'b0; bus.rdata = '0; bus.addr = '0;
        bus.err = 1'b0; bus.err_plus2 = 1'b0; clr = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = M_NONE; m_exp = '0; m_live = 0; m_cnt = 0; m_viol = '0; m_first = 0;
        s_addr = '0; s_rd = '0; s_err = 1'b0; s_ep2 = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Advance one clock, updating the reference model from the inputs
    // presented during this cycle.
    task automatic tick();
        logic [7:0] nv;
        bit acc, differs;
        int lo;
        nv = '0;
        acc = (m_mode != M_NONE) && bus.valid && bus.ready && !bus.branch;
        differs = (bus.addr != s_addr) || (bus.err != s_err) || (bus.err_plus2 != s_ep2) ||
                  (!s_err && bus.rdata[15:0] != s_rd[15:0]) ||
                  (!s_err && s_rd[1:0] == 2'b11 && bus.rdata[31:16] != s_rd[31:16]);
        if (bus.ready && !bus.req) nv[0] = 1'b1;
        if (bus.branch && bus.branch_addr[0]) nv[1] = 1'b1;
        if (bus.branch && !bus.branch_spec) nv[2] = 1'b1;
        if (m_mode == M_NONE && bus.ready && !bus.branch) nv[3] = 1'b1;
        if (m_mode == M_HOLD && !bus.branch && !bus.valid) nv[4] = 1'b1;
        if (m_mode == M_HOLD && !bus.branch && bus.valid && differs) nv[5] = 1'b1;
        if (acc && bus.addr != m_exp) nv[6] = 1'b1;
        // waiting cycles since the cache was armed
        if (m_mode != M_ARMED || bus.valid || bus.branch) m_live = 0;
        else if (bus.req && bus.ready && m_live < TO) begin
            m_live++;
            if (m_live == TO) nv[7] = 1'b1;
        end
        if (bus.branch) begin
            m_mode = M_ARMED; m_exp = bus.branch_addr;
        end else if (acc) begin
            if (bus.err) m_mode = M_NONE;
            else begin
                m_mode = M_ARMED;
                m_exp = m_exp + ((bus.rdata[1:0] == 2'b11) ? 32'd4 : 32'd2);
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (m_mode == M_ARMED && bus.valid) begin
            m_mode = M_HOLD;
            s_addr = bus.addr; s_rd = bus.rdata; s_err = bus.err; s_ep2 = bus.err_plus2;
        end else if (m_mode == M_HOLD && !bus.valid) begin
            m_mode = M_ARMED;
        end
        lo = 0;
        for (int i = 7; i >= 0; i--) if (nv[i]) lo = i;
        if (clr) begin
            m_viol = nv; m_first = (nv != 0) ? lo : 0;
        end else begin
            if (m_viol == 0 && nv != 0) m_first = lo;
            m_viol = m_viol | nv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [31:0] a);
        bus.branch = 1'b1; bus.branch_addr = a; bus.branch_spec = 1'b1;
        bus.req = 1'b1; bus.ready = 1'b0; bus.valid = 1'b0;
        tick();
        bus.branch = 1'b0;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bus.valid = 1'b1; bus.addr = a; bus.rdata = d; bus.ready = rdy; bus.req = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL reset_viol got %h want 00", v0); end
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", a0); end
        checks++; if (f0 !== 3'd0) begin errors++; $display("FAIL reset_first got %0d want 0", f0); end
        checks++; if (c0 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", c0); end
    endtask

    task automatic test_sequence();
        do_reset();
        branch_to(32'h100);
        offer(32'h100, 32'h0000_0001, 1'b1);
        offer(32'h102, 32'h0000_0013, 1'b1);
        offer(32'h106, 32'h0000_0001, 1'b1);
        bus.valid = 1'b0; bus.ready = 1'b0;
        tick();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL seq_viol got %h want 00", v0); end
        checks++; if (c0 !== 4'd3) begin errors++; $display("FAIL seq_cnt got %0d want 3", c0); end
    endtask

    task automatic test_addr_mismatch();
        do_reset();
        branch_to(32'h100);
        offer(32'h104, 32'h0000_0013, 1'b1);
        checks++; if (v0 !== 8'h40) begin errors++; $display("FAIL mism_viol got %h want 40", v0); end
        checks++; if (f0 !== 3'd6) begin errors++; $display("FAIL mism_first got %0d want 6", f0); end
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL mism_any got %b want 1", a0); end
    endtask

    task automatic test_dropped_valid();
        do_reset();
        branch_to(32'h200);
        offer(32'h200, 32'h0000_0013, 1'b0);
        offer(32'h200, 32'h0000_0013, 1'b0);
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL hold_viol got %h want 00", v0); end
        bus.valid = 1'b0;
        tick();
        checks++; if (v0 !== 8'h10) begin errors++; $display("FAIL drop_viol got %h want 10", v0); end
        checks++; if (f0 !== 3'd4) begin errors++; $display("FAIL drop_first got %0d want 4", f0); end
        do_reset();
        branch_to(32'h200);
        offer(32'h200, 32'h0000_0013, 1'b0);
        offer(32'h200, 32'h0000_0013, 1'b0);
        bus.valid = 1'b0;
        branch_to(32'h200);
        tick();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL drop_branch got %h want 00", v0); end
        // changed data while stalled
        offer(32'h200, 32'h0000_0013, 1'b0);
        offer(32'h200, 32'h0000_0017, 1'b0);
        checks++; if (v0 !== 8'h20) begin errors++; $display("FAIL unstable got %h want 20", v0); end
    endtask

    task automatic test_timeout();
        do_reset();
        branch_to(32'h300);
        bus.ready = 1'b1; bus.req = 1'b1; bus.valid = 1'b0;
        repeat (3) tick();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL to_early got %h want 00", v0); end
        tick();
        checks++; if (v0 !== 8'h80) begin errors++; $display("FAIL to_set got %h want 80", v0); end
        checks++; if (f0 !== 3'd7) begin errors++; $display("FAIL to_first got %0d want 7", f0); end
        repeat (3) tick();
        checks++; if (v1 !== 8'h00) begin errors++; $display("FAIL to_disabled got %h want 00", v1); end
        // reset mid-wait discards the partial count
        do_reset();
        branch_to(32'h300);
        bus.ready = 1'b1;
        repeat (2) tick();
        do_reset();
        branch_to(32'h300);
        bus.ready = 1'b1;
        repeat (3) tick();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL to_rst got %h want 00", v0); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req = 1'b0; bus.ready = 1'b1;
        tick();
        checks++; if (v0 !== 8'h09) begin errors++; $display("FAIL sim_viol got %h want 09", v0); end
        checks++; if (f0 !== 3'd0) begin errors++; $display("FAIL sim_first got %0d want 0", f0); end
        clr = 1'b1;
        branch_to(32'h3);
        clr = 1'b0;
        checks++; if (v0 !== 8'h02) begin errors++; $display("FAIL clr_viol got %h want 02", v0); end
        checks++; if (f0 !== 3'd1) begin errors++; $display("FAIL clr_first got %0d want 1", f0); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        branch_to(32'hFFFF_FFFE);
        offer(32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        offer(32'h0000_0000, 32'h0000_0001, 1'b1);
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL wrap_viol got %h want 00", v0); end
        checks++; if (c0 !== 4'd2) begin errors++; $display("FAIL wrap_cnt got %0d want 2", c0); end
        offer(32'h0000_0002, 32'h0000_0013, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({v0, a0, f0, c0} !== 16'h0) begin
            errors++; $display("FAIL rst_hold got viol=%h any=%b first=%0d cnt=%0d want 0", v0, a0, f0, c0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        bus.valid = 1'b0; bus.ready = 1'b0;
        tick();
        checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL rst_release got %h want 00", v0); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.branch = ($urandom_range(0, 99) < 6);
            bus.branch_spec = ($urandom_range(0, 19) != 0);
            bus.branch_addr = $urandom;
            bus.branch_addr[0] = ($urandom_range(0, 9) == 0);
            bus.req = ($urandom_range(0, 19) != 0);
            bus.ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 49) == 0);
            if (m_mode == M_HOLD && $urandom_range(0, 9) != 0) begin
                bus.valid = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 9) == 0) bus.rdata = $urandom;
            end else begin
                bus.valid = $urandom_range(0, 1);
                bus.addr = ($urandom_range(0, 6) != 0) ? m_exp : ($urandom & 32'hFFFF_FFFE);
                bus.rdata = $urandom;
                bus.err = ($urandom_range(0, 19) == 0);
                bus.err_plus2 = $urandom_range(0, 1);
            end
            tick();
            checks++; if (v0 !== m_viol) begin errors++; $display("FAIL rnd_viol cyc %0d got %h want %h", n, v0, m_viol); end
            checks++; if (a0 !== (m_viol != 0)) begin errors++; $display("FAIL rnd_any cyc %0d got %b want %b", n, a0, m_viol != 0); end
            checks++; if (f0 !== 3'(m_first)) begin errors++; $display("FAIL rnd_first cyc %0d got %0d want %0d", n, f0, m_first); end
            checks++; if (c0 !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, c0, m_cnt); end
        end
        checks++; if (v1[7] !== 1'b0) begin errors++; $display("FAIL rnd_no_timeout got %b want 0", v1[7]); end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_sequence();
        test_addr_mismatch();
        test_dropped_valid();
        test_timeout();
        test_simultaneous();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibex_icache_fetch_checker.md
IBEX_ICACHE_FETCH_CHECKER -- requirements
Module: ibex_icache_fetch_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of branch_addr/addr.
REQ-002 SHALL have parameter TIMEOUT, default 64, the liveness window in cycles; 0 disables the liveness check.
REQ-003 SHALL have parameter CNT_W, default 16, the fetch counter width.
REQ-004 SHALL have ports:
- clk  input  1  clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- req  input  1  core awake
- branch  input  1  redirect
- branch_spec  input  1  speculative redirect
- branch_addr  input  ADDR_W  redirect target
- ready  input  1  core accepts
- valid  input  1  cache offers
- rdata  input  32  instruction data
- addr  input  ADDR_W  response address
- err  input  1  response error
- err_plus2  input  1  error in upper halfword
- clr  input  1  clear sticky violations
- viol_o  output  8  sticky violation vector
- viol_any_o  output  1  OR of viol_o
- viol_first_o  output  3  index of first violation since reset or clr
- fetch_cnt_o  output  CNT_W  accepted non-error fetches

Function
REQ-005 SHALL implement FSM NO_ADDR, ARMED, HOLD.
REQ-006 SHALL move from any state to ARMED on branch, loading exp_addr = branch_addr; branch has priority over all other transitions.
REQ-007 SHALL define accept = valid & ready & ~branch in ARMED or HOLD.
- accept & ~err: stay/return to ARMED.
- exp_addr += 2 if rdata[1:0] != 2'b11, else += 4, modulo 2^ADDR_W.
- Increment fetch_cnt_o, saturating at all-ones.
REQ-008 SHALL move to NO_ADDR on accept & err; fetch_cnt_o and exp_addr unchanged.
REQ-009 SHALL move from ARMED to HOLD on valid & ~ready & ~branch, capturing addr, err, err_plus2, rdata[15:0], and rdata[31:16] when rdata[1:0]==2'b11.
REQ-010 SHALL, in HOLD with ~branch & ~valid, set bit 4 VALID_DROPPED and go to ARMED.
REQ-011 SHALL, in HOLD with valid, set bit 5 RESP_UNSTABLE when any of the following differs from its capture:
- addr, err or err_plus2;
- rdata[15:0], compared only if the captured err is 0;
- rdata[31:16], compared only if the captured err is 0 and the captured instruction is uncompressed.
REQ-012 SHALL set the remaining violation bits:
- bit 0 NO_READY_WITHOUT_REQ: ready & ~req.
- bit 1 BRANCH_MISALIGNED: branch & branch_addr[0].
- bit 2 BRANCH_NO_SPEC: branch & ~branch_spec.
- bit 3 FETCH_NO_ADDR: ready in NO_ADDR without branch.
- bit 6 ADDR_SEQ: accept with addr != exp_addr.
- bit 7 TIMEOUT: liveness counter reaches TIMEOUT.
REQ-013 SHALL run the liveness counter only when req & ready & ~valid in ARMED; it clears on valid, branch or state exit, saturates at TIMEOUT, and flags once per saturation.
REQ-014 SHALL keep violation bits sticky until clr; a violation in the same cycle as clr SHALL win and remain set.
REQ-015 SHALL latch viol_first_o on the first cycle any bit sets while viol_o==0, choosing the lowest index among simultaneous bits; clr SHALL return it to 0.
REQ-016 SHALL register all outputs; a violation appears in viol_o one cycle after the offending input.

Reset
REQ-017 SHALL, while rst_n is low, set state NO_ADDR, exp_addr 0, captured regs 0, counters 0, viol_o 0, viol_any_o 0, viol_first_o 0, fetch_cnt_o 0.
REQ-018 SHALL, when reset asserts mid-HOLD or mid-timeout, discard all tracking; no violation is reported on reset release.

Configuration
REQ-019 SHALL, when IBEX_FETCH_CHECKER_ASSERT_EN is defined, compile in one concurrent assertion per violation bit (disabled when !rst_n) plus assertions that control inputs are never X when rst_n is high; without the macro, only the flag outputs exist and behaviour is otherwise identical.

Structure
REQ-020 SHALL place the FSM state enum, the violation index enum (8 entries) and the NUM_VIOL=8 constant in package ibex_icache_fetch_checker_pkg.
REQ-021 SHALL use one sub-module, ibex_icache_fetch_checker_hold, to contain the capture registers and the stability compare.

Verification
REQ-022 SHALL cover the following scenarios:
- Sequence check: branch 0x100; accept rdata 0x0001 at 0x100, then 0x00000013 at 0x102, then 0x106 -> viol_o==0, fetch_cnt_o==3.
- Address mismatch: branch 0x100; accept at 0x104 -> viol_o==0x40, viol_first_o==6.
- Dropped valid: valid at 0x200 with ready low for 2 cycles, then valid low -> bit 4 set; branch during the hold instead -> no violation.
- Timeout: TIMEOUT=4, req & ready & ~valid for 4 cycles in ARMED -> bit 7 set on cycle 5; TIMEOUT=0 -> never set.
- Simultaneous faults: ready with req=0 in NO_ADDR -> viol_o==0x09, viol_first_o==0; assert clr with a new branch_addr 0x3 -> viol_o==0x02.
- Wrap and reset: branch 0xFFFFFFFE, accept a compressed instruction -> exp_addr wraps to 0x0; rst_n low mid-HOLD -> all outputs 0.
